// File: rtl/mem_wb_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mem_wb_if: MEM->WB handshake and payload bundle                      |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
interface mem_wb_if #(
    parameter int WIDTH     = 32,
    parameter int REGADDR_W = 5
);
    logic                 flush;
    logic                 in_valid;
    logic                 in_ready;
    logic                 in_regwrite;
    logic                 in_memtoreg;
    logic [WIDTH-1:0]     in_aluout;
    logic [WIDTH-1:0]     in_readdata;
    logic [REGADDR_W-1:0] in_regaddr;
    logic                 out_valid;
    logic                 out_ready;
    logic                 out_regwrite;
    logic [WIDTH-1:0]     out_wbdata;
    logic [WIDTH-1:0]     out_aluout;
    logic [REGADDR_W-1:0] out_regaddr;
    logic [1:0]           occ;

    // Stage view
    modport master (
        input  flush, in_valid, in_regwrite, in_memtoreg, in_aluout,
               in_readdata, in_regaddr, out_ready,
        output in_ready, out_valid, out_regwrite, out_wbdata, out_aluout,
               out_regaddr, occ
    );

    // Pipeline / environment view
    modport slave (
        output flush, in_valid, in_regwrite, in_memtoreg, in_aluout,
               in_readdata, in_regaddr, out_ready,
        input  in_ready, out_valid, out_regwrite, out_wbdata, out_aluout,
               out_regaddr, occ
    );
endinterface
`default_nettype wire

// File: rtl/mem_wb_stage.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mem_wb_stage: elastic MEM->WB stage with optional skid entry and     |
// | pre-selected write-back data.                                        |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module mem_wb_stage #(
    parameter int WIDTH     = 32,
    parameter int REGADDR_W = 5,
    parameter int SKID      = 1
) (
    input  wire logic clk,
    input  wire logic rst,
    mem_wb_if.master  bus
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    state_t               r_state;
    logic                 r_main_rw;
    logic [REGADDR_W-1:0] r_main_ra;
    logic [WIDTH-1:0]     r_main_alu;
    logic [WIDTH-1:0]     r_main_wb;
    logic                 r_skid_rw;
    logic [REGADDR_W-1:0] r_skid_ra;
    logic [WIDTH-1:0]     r_skid_alu;
    logic [WIDTH-1:0]     r_skid_wb;

    logic                 w_in_ready;
    logic                 w_out_valid;
    logic                 w_accept;
    logic                 w_drain;
    logic                 w_cap_rw;
    logic [WIDTH-1:0]     w_cap_wb;
    state_t               w_state_nxt;
    logic                 w_load_main;
    logic                 w_load_skid;
    logic                 w_main_from_skid;

    generate
        if (SKID != 0) begin : g_skid
            // Ready comes straight from the state flop: no path from out_ready.
            assign w_in_ready = (r_state != ST_TWO);
        end else begin : g_noskid
            assign w_in_ready = (r_state == ST_EMPTY) | bus.out_ready;
        end
    endgenerate

    assign w_out_valid = (r_state != ST_EMPTY);
    assign w_accept    = bus.in_valid & w_in_ready;
    assign w_drain     = w_out_valid & bus.out_ready;

    // $0 suppression is folded in at capture so the output is a plain AND.
    assign w_cap_rw = bus.in_regwrite & (bus.in_regaddr != '0);
    assign w_cap_wb = bus.in_memtoreg ? bus.in_readdata : bus.in_aluout;

    always_comb begin
        w_state_nxt      = r_state;
        w_load_main      = 1'b0;
        w_load_skid      = 1'b0;
        w_main_from_skid = 1'b0;
        case (r_state)
            ST_EMPTY: begin
                if (w_accept) begin
                    w_load_main = 1'b1;
                    w_state_nxt = ST_ONE;
                end
            end
            ST_ONE: begin
                if (w_accept && w_drain) begin
                    w_load_main = 1'b1;
                end else if (w_accept) begin
                    if (SKID != 0) begin
                        w_load_skid = 1'b1;
                        w_state_nxt = ST_TWO;
                    end else begin
                        w_load_main = 1'b1;
                    end
                end else if (w_drain) begin
                    w_state_nxt = ST_EMPTY;
                end
            end
            ST_TWO: begin
                if (w_drain) begin
                    w_main_from_skid = 1'b1;
                    w_state_nxt      = ST_ONE;
                end
            end
            default: w_state_nxt = ST_EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= ST_EMPTY;
            r_main_rw  <= 1'b0;
            r_main_ra  <= '0;
            r_main_alu <= '0;
            r_main_wb  <= '0;
            r_skid_rw  <= 1'b0;
            r_skid_ra  <= '0;
            r_skid_alu <= '0;
            r_skid_wb  <= '0;
        end else if (bus.flush) begin
            // Payload may go stale; everything visible is gated by out_valid.
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_nxt;
            if (w_load_main) begin
                r_main_rw  <= w_cap_rw;
                r_main_ra  <= bus.in_regaddr;
                r_main_alu <= bus.in_aluout;
                r_main_wb  <= w_cap_wb;
            end else if (w_main_from_skid) begin
                r_main_rw  <= r_skid_rw;
                r_main_ra  <= r_skid_ra;
                r_main_alu <= r_skid_alu;
                r_main_wb  <= r_skid_wb;
            end
            if (w_load_skid) begin
                r_skid_rw  <= w_cap_rw;
                r_skid_ra  <= bus.in_regaddr;
                r_skid_alu <= bus.in_aluout;
                r_skid_wb  <= w_cap_wb;
            end
        end
    end

    assign bus.in_ready     = w_in_ready;
    assign bus.out_valid    = w_out_valid;
    assign bus.out_regwrite = w_out_valid & r_main_rw;
    assign bus.out_wbdata   = r_main_wb;
    assign bus.out_aluout   = r_main_alu;
    assign bus.out_regaddr  = r_main_ra;
    assign bus.occ          = r_state;

endmodule
`default_nettype wire

// File: tb/tb_mem_wb_stage.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_mem_wb_stage: queue-model bench for SKID=1 and SKID=0 builds      |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_mem_wb_stage;
    localparam int W  = 32;
    localparam int RW = 5;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic          flush = 0, in_valid = 0, in_regwrite = 0, in_memtoreg = 0, out_ready = 0;
    logic [W-1:0]  in_aluout = 0, in_readdata = 0;
    logic [RW-1:0] in_regaddr = 0;

    mem_wb_if #(.WIDTH(W), .REGADDR_W(RW)) b1 ();
    mem_wb_if #(.WIDTH(W), .REGADDR_W(RW)) b0 ();

    assign b1.flush = flush;       assign b0.flush = flush;
    assign b1.in_valid = in_valid; assign b0.in_valid = in_valid;
    assign b1.in_regwrite = in_regwrite; assign b0.in_regwrite = in_regwrite;
    assign b1.in_memtoreg = in_memtoreg; assign b0.in_memtoreg = in_memtoreg;
    assign b1.in_aluout = in_aluout;     assign b0.in_aluout = in_aluout;
    assign b1.in_readdata = in_readdata; assign b0.in_readdata = in_readdata;
    assign b1.in_regaddr = in_regaddr;   assign b0.in_regaddr = in_regaddr;
    assign b1.out_ready = out_ready;     assign b0.out_ready = out_ready;

    mem_wb_stage #(.WIDTH(W), .REGADDR_W(RW), .SKID(1)) dut1 (.clk(clk), .rst(rst), .bus(b1));
    mem_wb_stage #(.WIDTH(W), .REGADDR_W(RW), .SKID(0)) dut0 (.clk(clk), .rst(rst), .bus(b0));

    typedef struct {
        logic          rw;
        logic [RW-1:0] ra;
        logic [W-1:0]  alu;
        logic [W-1:0]  wb;
    } ent_t;

    ent_t q1[$];
    ent_t q0[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    bit   chk_en   = 0;
    bit   a1, a0;
    ent_t e;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Reference: each build is a FIFO of capacity 2 (SKID=1) or a single slot
    // that can be refilled in the cycle it is consumed (SKID=0).
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            q1.delete();
            q0.delete();
        end else if (flush) begin
            q1.delete();
            q0.delete();
        end else begin
            e.rw  = in_regwrite && (in_regaddr != 0);
            e.ra  = in_regaddr;
            e.alu = in_aluout;
            e.wb  = in_memtoreg ? in_readdata : in_aluout;
            a1 = in_valid && (q1.size() < 2);
            a0 = in_valid && ((q0.size() == 0) || out_ready);
            if (q1.size() > 0 && out_ready) void'(q1.pop_front());
            if (q0.size() > 0 && out_ready) void'(q0.pop_front());
            if (a1) q1.push_back(e);
            if (a0) q0.push_back(e);
        end
    end

    always @(negedge clk) begin
        if (chk_en && rst) begin
            chk("s1_valid", b1.out_valid, q1.size() > 0);
            chk("s1_occ", b1.occ, q1.size());
            chk("s1_ready", b1.in_ready, q1.size() < 2);
            chk("s1_regwrite", b1.out_regwrite, (q1.size() > 0) && q1[0].rw);
            if (q1.size() > 0) begin
                chk("s1_wbdata", b1.out_wbdata, q1[0].wb);
                chk("s1_aluout", b1.out_aluout, q1[0].alu);
                chk("s1_regaddr", b1.out_regaddr, q1[0].ra);
            end
            chk("s0_valid", b0.out_valid, q0.size() > 0);
            chk("s0_occ", b0.occ, q0.size());
            chk("s0_ready", b0.in_ready, (q0.size() == 0) || out_ready);
            chk("s0_regwrite", b0.out_regwrite, (q0.size() > 0) && q0[0].rw);
            if (q0.size() > 0) begin
                chk("s0_wbdata", b0.out_wbdata, q0[0].wb);
                chk("s0_aluout", b0.out_aluout, q0[0].alu);
                chk("s0_regaddr", b0.out_regaddr, q0[0].ra);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic present(input logic [W-1:0] alu, input logic m2r, input logic [W-1:0] rd,
                           input logic [RW-1:0] ra, input logic rw);
        in_valid    = 1'b1;
        in_aluout   = alu;
        in_memtoreg = m2r;
        in_readdata = rd;
        in_regaddr  = ra;
        in_regwrite = rw;
    endtask

    task automatic idle(input int n);
        in_valid  = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b1;
        repeat (n) step();
    endtask

    logic [W-1:0] exp_stream [8];

    initial begin
        exp_stream = '{32'h1, 32'h102, 32'h3, 32'h104, 32'h5, 32'h106, 32'h7, 32'h108};

        #3;
        chk("rst_valid", b1.out_valid, 0);
        chk("rst_occ", b1.occ, 0);
        chk("rst_ready1", b1.in_ready, 1);
        chk("rst_ready0", b0.in_ready, 1);
        chk("rst_wbdata", b1.out_wbdata, 0);
        chk("rst_regaddr", b0.out_regaddr, 0);
        step();
        step();
        rst    = 1'b1;
        chk_en = 1'b1;

        // Back-to-back stream, alternating load / ALU write-back
        out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            present(W'(i), (i % 2) == 0, W'(32'h100 + i), RW'(i), 1'b1);
            step();
            chk("stream_valid", b1.out_valid, 1);
            chk("stream_wbdata", b1.out_wbdata, exp_stream[i-1]);
            chk("stream_wbdata0", b0.out_wbdata, exp_stream[i-1]);
        end
        idle(2);

        // Back-pressure into the skid entry
        out_ready = 1'b0;
        present(32'hA1, 0, 0, 5'd1, 1); step();
        chk("bp_occ1", b1.occ, 1); chk("bp_rdy1", b1.in_ready, 1);
        present(32'hB2, 0, 0, 5'd2, 1); step();
        chk("bp_occ2", b1.occ, 2); chk("bp_rdy2", b1.in_ready, 0);
        present(32'hC3, 0, 0, 5'd3, 1); step();
        chk("bp_occ3", b1.occ, 2); chk("bp_alu3", b1.out_aluout, 32'hA1);
        out_ready = 1'b1; step();
        chk("bp_occ4", b1.occ, 1); chk("bp_alu4", b1.out_aluout, 32'hB2);
        chk("bp_rdy4", b1.in_ready, 1);
        step();
        chk("bp_alu5", b1.out_aluout, 32'hC3); chk("bp_occ5", b1.occ, 1);
        in_valid = 1'b0; step();
        chk("bp_occ6", b1.occ, 0);
        idle(2);

        // Writes to $0 are suppressed
        present(32'hDEADBEEF, 0, 32'h55, 5'd0, 1); step();
        chk("r0_valid", b1.out_valid, 1);
        chk("r0_regwrite", b1.out_regwrite, 0);
        chk("r0_wbdata", b1.out_wbdata, 32'hDEADBEEF);
        present(32'hDEADBEEF, 0, 32'h55, 5'd5, 1); step();
        chk("r5_regwrite", b1.out_regwrite, 1);
        idle(2);

        // Flush with both entries held and a new input presented
        out_ready = 1'b0;
        present(32'h11, 0, 0, 5'd7, 1); step();
        present(32'h22, 0, 0, 5'd8, 1); step();
        chk("fl_occ_pre", b1.occ, 2);
        present(32'hF1F1, 0, 0, 5'd9, 1);
        flush = 1'b1; step();
        chk("fl_valid", b1.out_valid, 0);
        chk("fl_occ", b1.occ, 0);
        chk("fl_occ0", b0.occ, 0);
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("fl_gone", b1.out_valid, 0);
        end

        // SKID=0: combinational ready, same-edge drain and accept
        out_ready = 1'b0;
        present(32'h33, 0, 0, 5'd3, 1); step();
        chk("s0_occ_hold", b0.occ, 1);
        chk("s0_rdy_low", b0.in_ready, 0);
        present(32'h44, 0, 0, 5'd4, 1);
        out_ready = 1'b1; #1;
        chk("s0_rdy_high", b0.in_ready, 1);
        step();
        chk("s0_occ_keep", b0.occ, 1);
        chk("s0_alu_new", b0.out_aluout, 32'h44);
        idle(3);

        // Asynchronous reset with two entries held
        out_ready = 1'b0;
        present(32'h66, 1, 32'h77, 5'd6, 1); step();
        present(32'h88, 1, 32'h99, 5'd6, 1); step();
        chk("ar_occ_pre", b1.occ, 2);
        #2; rst = 1'b0; #1;
        chk("ar_valid", b1.out_valid, 0);
        chk("ar_occ", b1.occ, 0);
        chk("ar_ready", b1.in_ready, 1);
        chk("ar_regwrite", b1.out_regwrite, 0);
        chk("ar_wbdata", b1.out_wbdata, 0);
        chk("ar_aluout", b1.out_aluout, 0);
        chk("ar_regaddr", b1.out_regaddr, 0);
        chk("ar_occ0", b0.occ, 0);
        #3; rst = 1'b1;
        idle(2);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            in_valid    = ($urandom % 4) != 0;
            out_ready   = ($urandom % 3) != 0;
            flush       = ($urandom % 40) == 0;
            in_regwrite = $urandom % 2;
            in_memtoreg = $urandom % 2;
            in_aluout   = $urandom;
            in_readdata = $urandom;
            in_regaddr  = (($urandom % 4) == 0) ? 5'd0 : RW'($urandom);
            step();
        end
        idle(3);
        chk_en = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
`default_nettype wire
